// File: rtl/io_pkg.sv
// Shared definitions for the I/O slot peripherals: SPI engine states and
// the SPI slot register word offsets.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPHA_DLY = 2'd1,
    P0       = 2'd2,
    P1       = 2'd3
  } spi_state_t;

  localparam logic [4:0] SPI_DATA_A = 5'd0;
  localparam logic [4:0] SPI_CTRL_A = 5'd1;
  localparam logic [4:0] SPI_SS_A   = 5'd2;
  localparam logic [4:0] SPI_STAT_A = 5'd3;

endpackage

// File: rtl/spi_engine.sv
// Single-transfer SPI master engine: half-period counter, bit counter,
// tx/rx shifters and a registered serial clock for all four CPOL/CPHA modes.
module spi_engine
  import io_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DVSR_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] din,
  input  logic [DVSR_W-1:0]    dvsr,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 miso,
  output logic [DATA_BITS-1:0] dout,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 ready,
  output logic                 done_tick,
  output spi_state_t           state
);

  localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [NW-1:0] LAST_BIT = NW'(DATA_BITS - 1);

  spi_state_t           state_q, state_d;
  logic [DVSR_W-1:0]    c_q, c_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] tx_q, tx_d;
  logic [DATA_BITS-1:0] rx_q, rx_d;
  logic                 sclk_q, sclk_d;
  logic                 half_end;
  logic                 sclk_core;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      c_q     <= '0;
      n_q     <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      n_q     <= n_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
    end
  end

  assign half_end = (c_q == dvsr);

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    n_d       = n_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    done_tick = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tx_d    = din;
          n_d     = '0;
          c_d     = '0;
          state_d = cpha ? CPHA_DLY : P0;
        end
      end
      CPHA_DLY: begin
        if (half_end) begin
          c_d     = '0;
          state_d = P0;
        end else begin
          c_d = c_q + DVSR_W'(1);
        end
      end
      P0: begin
        if (half_end) begin
          c_d     = '0;
          rx_d    = {rx_q[DATA_BITS-2:0], miso};
          state_d = P1;
        end else begin
          c_d = c_q + DVSR_W'(1);
        end
      end
      P1: begin
        if (half_end) begin
          c_d = '0;
          if (n_q == LAST_BIT) begin
            done_tick = 1'b1;
            state_d   = IDLE;
          end else begin
            tx_d    = {tx_q[DATA_BITS-2:0], 1'b0};
            n_d     = n_q + NW'(1);
            state_d = P0;
          end
        end else begin
          c_d = c_q + DVSR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // sclk is decoded from the next state and registered so it lines up with
  // state_q and never glitches.
  assign sclk_core = ((state_d == P1) && !cpha) || ((state_d == P0) && cpha);
  assign sclk_d    = sclk_core ^ cpol;

  assign sclk  = sclk_q;
  assign mosi  = tx_q[DATA_BITS-1];
  assign dout  = rx_q;
  assign ready = (state_q == IDLE);
  assign state = state_q;

endmodule

// File: rtl/spi_slot.sv
// SPI master peripheral for I/O slot 1: register file, software slave
// select, sticky rx_valid flag and read mux around spi_engine.
module spi_slot
  import io_pkg::*;
#(
  parameter int              DATA_BITS  = 8,
  parameter int              DVSR_W     = 16,
  parameter logic [DVSR_W-1:0] RESET_DVSR = 16'd49
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_ss_n
);

  // Bus protocol: read and write are single-cycle strobes that only count
  // when cs is high; rd_data is valid combinationally for the current addr.
  logic wr_en, rd_en;
  assign wr_en = cs & write;
  assign rd_en = cs & read;

  logic [DVSR_W-1:0]    dvsr_q, dvsr_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic                 ss_n_q, ss_n_d;
  logic [DATA_BITS-1:0] rx_q, rx_d;
  logic                 rx_valid_q, rx_valid_d;

  logic                 start;
  logic                 busy;
  logic                 eng_ready;
  logic                 eng_done;
  logic [DATA_BITS-1:0] eng_dout;
  spi_state_t           eng_state;

  assign busy = (eng_state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvsr_q     <= RESET_DVSR;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      rx_q       <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      dvsr_q     <= dvsr_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      ss_n_q     <= ss_n_d;
      rx_q       <= rx_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    dvsr_d     = dvsr_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    ss_n_d     = ss_n_q;
    rx_d       = rx_q;
    rx_valid_d = rx_valid_q;
    start      = wr_en && (addr == SPI_DATA_A) && !busy;
    if (wr_en && (addr == SPI_CTRL_A) && !busy) begin
      dvsr_d = wr_data[DVSR_W-1:0];
      cpol_d = wr_data[DVSR_W];
      cpha_d = wr_data[DVSR_W+1];
    end
    if (wr_en && (addr == SPI_SS_A)) begin
      ss_n_d = wr_data[0];
    end
    // Completion outranks a same-cycle DATA read so a fresh byte is never lost.
    if (eng_done) begin
      rx_d       = eng_dout;
      rx_valid_d = 1'b1;
    end else if (rd_en && (addr == SPI_DATA_A)) begin
      rx_valid_d = 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      SPI_DATA_A: rd_data[DATA_BITS-1:0] = rx_q;
      SPI_CTRL_A: begin
        rd_data[DVSR_W-1:0] = dvsr_q;
        rd_data[DVSR_W]     = cpol_q;
        rd_data[DVSR_W+1]   = cpha_q;
      end
      SPI_SS_A:   rd_data[0] = ss_n_q;
      SPI_STAT_A: rd_data[1:0] = {rx_valid_q, eng_ready};
      default:    rd_data = '0;
    endcase
  end

  logic unused_wr_bits;
  assign unused_wr_bits = ^wr_data[31:DVSR_W+2];

  spi_engine #(
    .DATA_BITS (DATA_BITS),
    .DVSR_W    (DVSR_W)
  ) u_engine (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (wr_data[DATA_BITS-1:0]),
    .dvsr      (dvsr_q),
    .cpol      (cpol_q),
    .cpha      (cpha_q),
    .miso      (spi_miso),
    .dout      (eng_dout),
    .sclk      (spi_sclk),
    .mosi      (spi_mosi),
    .ready     (eng_ready),
    .done_tick (eng_done),
    .state     (eng_state)
  );

  assign spi_ss_n = ss_n_q;

endmodule

// File: tb/tb_spi_slot.sv
// Bench for spi_slot: a mode table driven through a loopback/slave model,
// plus hand sequences for reset, busy writes, abort and coincident events.
module tb_spi_slot;
  import io_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0, read = 1'b0, write = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        spi_sclk, spi_mosi, spi_miso, spi_ss_n;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [7:0]  exp_q[$];

  logic        loop_en = 1'b1;
  logic [7:0]  slv_q = '0;
  logic        tb_cpol = 1'b0, tb_cpha = 1'b0;
  logic        sclk_prev = 1'b0;
  logic [7:0]  mon_q = '0;
  int          mon_cnt = 0;

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic [15:0] dvsr;
    logic [7:0]  tx;
    logic        loop;
    logic [7:0]  slv;
    logic [7:0]  exp_rx;
    int unsigned exp_cyc;
  } vec_t;
  vec_t vecs[5];

  spi_slot dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ss_n (spi_ss_n)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // slave model: captures mosi and advances its own shifter on each sampling edge
  assign spi_miso = loop_en ? spi_mosi : slv_q[7];
  always @(negedge clk) begin
    if ((spi_sclk !== sclk_prev) && ((spi_sclk ^ tb_cpol ^ tb_cpha) == 1'b1)) begin
      mon_q = {mon_q[6:0], spi_mosi};
      slv_q = {slv_q[6:0], 1'b0};
      mon_cnt++;
    end
    sclk_prev = spi_sclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; addr = a;
    #1 d = rd_data;
    @(negedge clk);
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic peek(input logic [4:0] a, output logic [31:0] d);
    addr = a;
    #1 d = rd_data;
  endtask

  task automatic wait_ready(input int unsigned start, input int unsigned limit,
                            output int unsigned elapsed);
    addr = SPI_STAT_A;
    #1;
    while (rd_data[0] == 1'b0 && (cyc - start) < limit) begin
      @(negedge clk);
      #1;
    end
    elapsed = cyc - start;
  endtask

  task automatic wait_until(input int unsigned start, input int unsigned n);
    while ((cyc - start) < n) @(negedge clk);
  endtask

  task automatic set_mode(input logic cpol, input logic cpha, input logic [15:0] dvsr);
    tb_cpol = cpol;
    tb_cpha = cpha;
    reg_write(SPI_CTRL_A, {14'd0, cpha, cpol, dvsr});
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int unsigned st, el;

    vecs[0] = '{cpol: 1'b0, cpha: 1'b0, dvsr: 16'd1, tx: 8'h5A, loop: 1'b1, slv: 8'h00, exp_rx: 8'h5A, exp_cyc: 32};
    vecs[1] = '{cpol: 1'b1, cpha: 1'b1, dvsr: 16'd0, tx: 8'h5A, loop: 1'b0, slv: 8'h3C, exp_rx: 8'h3C, exp_cyc: 17};
    vecs[2] = '{cpol: 1'b0, cpha: 1'b1, dvsr: 16'd2, tx: 8'hC3, loop: 1'b0, slv: 8'h96, exp_rx: 8'h96, exp_cyc: 51};
    vecs[3] = '{cpol: 1'b1, cpha: 1'b0, dvsr: 16'd0, tx: 8'h0F, loop: 1'b1, slv: 8'h00, exp_rx: 8'h0F, exp_cyc: 16};
    vecs[4] = '{cpol: 1'b0, cpha: 1'b0, dvsr: 16'd3, tx: 8'h81, loop: 1'b0, slv: 8'h7E, exp_rx: 8'h7E, exp_cyc: 64};

    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // reset state
    peek(SPI_CTRL_A, d); check("rst_ctrl", d, 32'h0000_0031);
    peek(SPI_SS_A, d);   check("rst_ss", d, 32'h1);
    peek(SPI_STAT_A, d); check("rst_status", d, 32'h1);
    peek(SPI_DATA_A, d); check("rst_data", d, 32'h0);
    check("rst_sclk", {31'd0, spi_sclk}, 32'h0);
    check("rst_ss_n", {31'd0, spi_ss_n}, 32'h1);
    check("rst_mosi", {31'd0, spi_mosi}, 32'h0);

    // mode 0 loopback, dvsr=1, 0xA5 with sclk timing
    set_mode(1'b0, 1'b0, 16'd1);
    loop_en = 1'b1; mon_q = '0; mon_cnt = 0;
    reg_write(SPI_DATA_A, 32'hA5);
    st = cyc;
    exp_q.push_back(8'hA5);
    check("a5_sclk_t0", {31'd0, spi_sclk}, 32'h0);
    check("a5_mosi_b7", {31'd0, spi_mosi}, 32'h1);
    peek(SPI_STAT_A, d); check("a5_busy", d, 32'h0);
    @(negedge clk);
    check("a5_sclk_t1", {31'd0, spi_sclk}, 32'h0);
    @(negedge clk);
    check("a5_sclk_t2", {31'd0, spi_sclk}, 32'h1);
    repeat (2) @(negedge clk);
    check("a5_sclk_t4", {31'd0, spi_sclk}, 32'h0);
    check("a5_mosi_b6", {31'd0, spi_mosi}, 32'h0);
    wait_ready(st, 200, el);
    check("a5_cycles", el, 32);
    check("a5_mosi_bits", {24'd0, mon_q}, 32'hA5);
    reg_read(SPI_STAT_A, d); check("a5_status", d, 32'h3);
    reg_read(SPI_DATA_A, d); check("a5_rx", d, {24'd0, exp_q.pop_front()});
    reg_read(SPI_STAT_A, d); check("a5_status_clr", d, 32'h1);

    // mode table
    for (int i = 0; i < 5; i++) begin
      set_mode(vecs[i].cpol, vecs[i].cpha, vecs[i].dvsr);
      check($sformatf("v%0d_idle_sclk", i), {31'd0, spi_sclk}, {31'd0, vecs[i].cpol});
      loop_en = vecs[i].loop; slv_q = vecs[i].slv; mon_q = '0; mon_cnt = 0;
      reg_write(SPI_DATA_A, {24'd0, vecs[i].tx});
      st = cyc;
      exp_q.push_back(vecs[i].exp_rx);
      wait_ready(st, 2000, el);
      check($sformatf("v%0d_cycles", i), el, vecs[i].exp_cyc);
      check($sformatf("v%0d_mosi", i), {24'd0, mon_q}, {24'd0, vecs[i].tx});
      check($sformatf("v%0d_edges", i), mon_cnt, 8);
      reg_read(SPI_STAT_A, d); check($sformatf("v%0d_status", i), d, 32'h3);
      reg_read(SPI_DATA_A, d); check($sformatf("v%0d_rx", i), d, {24'd0, exp_q.pop_front()});
      reg_read(SPI_STAT_A, d); check($sformatf("v%0d_status_clr", i), d, 32'h1);
    end

    // writes while busy are ignored
    set_mode(1'b0, 1'b0, 16'd1);
    loop_en = 1'b1; mon_q = '0; mon_cnt = 0;
    reg_write(SPI_DATA_A, 32'h66);
    st = cyc;
    exp_q.push_back(8'h66);
    reg_write(SPI_DATA_A, 32'hFF);
    reg_write(SPI_CTRL_A, 32'h0);
    wait_ready(st, 200, el);
    check("busy_cycles", el, 32);
    check("busy_mosi", {24'd0, mon_q}, 32'h66);
    peek(SPI_CTRL_A, d); check("busy_ctrl", d, 32'h1);
    reg_read(SPI_DATA_A, d); check("busy_rx", d, {24'd0, exp_q.pop_front()});

    // DATA read in the completion cycle
    set_mode(1'b0, 1'b0, 16'd0);
    reg_write(SPI_DATA_A, 32'h99);
    st = cyc;
    exp_q.push_back(8'h99);
    wait_until(st, 15);
    cs = 1'b1; read = 1'b1; addr = SPI_DATA_A;
    @(negedge clk);
    cs = 1'b0; read = 1'b0;
    peek(SPI_STAT_A, d); check("coinc_status", d, 32'h3);

    // unmapped address
    reg_write(5'd7, 32'hFFFF_FFFF);
    reg_read(5'd7, d);        check("addr7_read", d, 32'h0);
    reg_read(5'd31, d);       check("addr31_read", d, 32'h0);
    reg_read(SPI_CTRL_A, d);  check("addr7_ctrl", d, 32'h0);
    reg_read(SPI_SS_A, d);    check("addr7_ss", d, 32'h1);
    reg_read(SPI_STAT_A, d);  check("addr7_status", d, 32'h3);
    reg_read(SPI_DATA_A, d);  check("coinc_rx", d, {24'd0, exp_q.pop_front()});

    // leave rx_valid set, then abort a transfer with reset
    reg_write(SPI_DATA_A, 32'h42);
    repeat (20) @(negedge clk);
    reg_write(SPI_SS_A, 32'h0);
    check("ss_low", {31'd0, spi_ss_n}, 32'h0);
    set_mode(1'b0, 1'b0, 16'd1);
    peek(SPI_STAT_A, d); check("pre_abort_status", d, 32'h3);
    reg_write(SPI_DATA_A, 32'hE7);
    st = cyc;
    wait_until(st, 14);
    check("abort_sclk_p1", {31'd0, spi_sclk}, 32'h1);
    reset = 1'b0;
    #2;
    check("abort_sclk", {31'd0, spi_sclk}, 32'h0);
    check("abort_ss_n", {31'd0, spi_ss_n}, 32'h1);
    check("abort_mosi", {31'd0, spi_mosi}, 32'h0);
    peek(SPI_STAT_A, d); check("abort_status", d, 32'h1);
    peek(SPI_DATA_A, d); check("abort_rx", d, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    peek(SPI_CTRL_A, d); check("abort_ctrl", d, 32'h0000_0031);
    check("abort_sclk_after", {31'd0, spi_sclk}, 32'h0);
    peek(SPI_STAT_A, d); check("abort_status_after", d, 32'h1);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
